// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared types and default sizes for the parametrised integer
//               register file (debug FSM state encoding, default widths).
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int unsigned DEF_XLEN  = 32;
  localparam int unsigned DEF_NREGS = 32;

  // Debug access sequencer states
  typedef enum logic [1:0] {
    DBG_IDLE   = 2'd0,
    DBG_ACCESS = 2'd1,
    DBG_DONE   = 2'd2
  } dbg_state_e;

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Per-register pending-write (busy) vector with NRD query ports.
//               A set and a clear hitting the same register in one cycle
//               leaves it busy. Query results mask out a register being
//               cleared this cycle, since its value is available via bypass.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               i_set/i_set_addr - mark register busy (issue)
//               i_clr/i_clr_addr - mark register free (writeback)
//               i_q_addr         - NRD packed query addresses
//               o_q_busy         - NRD busy flags
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = DEF_NREGS,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_set,
  input  logic [AW-1:0]     i_set_addr,
  input  logic              i_clr,
  input  logic [AW-1:0]     i_clr_addr,
  input  logic [NRD*AW-1:0] i_q_addr,
  output logic [NRD-1:0]    o_q_busy
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;

  // Clear first, then set, so that a simultaneous set on the same entry wins
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr) begin
      w_busy_nxt[i_clr_addr] = 1'b0;
    end
    if (i_set && !((ZERO_REG != 0) && (i_set_addr == '0))) begin
      w_busy_nxt[i_set_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  generate
    for (genvar k = 0; k < NRD; k++) begin : g_query
      logic [AW-1:0] w_qa;
      assign w_qa        = i_q_addr[k*AW +: AW];
      assign o_q_busy[k] = r_busy[w_qa] & ~(i_clr && (i_clr_addr == w_qa));
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb
// Description : Parametrised integer register file with NRD combinational
//               read ports (writeback bypass), pending-write scoreboard and
//               a request/acknowledge debug port. Core writeback always has
//               priority over a debug write; the debug write waits in ACCESS.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               we_i/waddr_i/wdata_i     - core writeback
//               raddr_i/rdata_o/rbusy_o  - packed read ports and busy flags
//               iss_valid_i/iss_rd_i     - issue of an instruction writing rd
//               dbg_req_i/dbg_we_i/dbg_addr_i/dbg_wdata_i - debug request
//               dbg_ack_o/dbg_rdata_o    - debug completion and read data
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN     = DEF_XLEN,
  parameter  int NREGS    = DEF_NREGS,
  parameter  int NRD      = 2,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we_i,
  input  logic [AW-1:0]       waddr_i,
  input  logic [XLEN-1:0]     wdata_i,
  input  logic [NRD*AW-1:0]   raddr_i,
  output logic [NRD*XLEN-1:0] rdata_o,
  output logic [NRD-1:0]      rbusy_o,
  input  logic                iss_valid_i,
  input  logic [AW-1:0]       iss_rd_i,
  input  logic                dbg_req_i,
  input  logic                dbg_we_i,
  input  logic [AW-1:0]       dbg_addr_i,
  input  logic [XLEN-1:0]     dbg_wdata_i,
  output logic                dbg_ack_o,
  output logic [XLEN-1:0]     dbg_rdata_o
);

  logic [XLEN-1:0] r_regs [NREGS];
  logic [XLEN-1:0] r_dbg_rdata;
  dbg_state_e      r_state;
  dbg_state_e      w_state_nxt;
  logic            w_capture;
  logic            w_ack;
  logic            w_core_wr;
  logic            w_dbg_wr;
  logic [XLEN-1:0] w_dbg_rv;

  // Read value of one address including the writeback bypass
  function automatic logic [XLEN-1:0] f_read(
    input logic [AW-1:0]   a,
    input logic [XLEN-1:0] stored,
    input logic            we,
    input logic [AW-1:0]   wa,
    input logic [XLEN-1:0] wd
  );
    if ((ZERO_REG != 0) && (a == '0)) return '0;
    if (we && (wa == a))              return wd;
    return stored;
  endfunction

  assign w_core_wr = we_i && ((waddr_i != '0) || (ZERO_REG == 0));
  // Debug write only in a cycle free of core writeback; x0 writes are dropped
  assign w_dbg_wr  = (r_state == DBG_ACCESS) && dbg_we_i && !we_i &&
                     ((dbg_addr_i != '0) || (ZERO_REG == 0));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (w_core_wr) begin
        r_regs[waddr_i] <= wdata_i;
      end
      if (w_dbg_wr) begin
        r_regs[dbg_addr_i] <= dbg_wdata_i;
      end
    end
  end

  generate
    for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0] w_ra;
      assign w_ra                    = raddr_i[k*AW +: AW];
      assign rdata_o[k*XLEN +: XLEN] = f_read(w_ra, r_regs[w_ra], we_i, waddr_i, wdata_i);
    end
  endgenerate

  assign w_dbg_rv = f_read(dbg_addr_i, r_regs[dbg_addr_i], we_i, waddr_i, wdata_i);

  // Debug sequencer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DBG_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_ack       = 1'b0;
    case (r_state)
      DBG_IDLE: begin
        if (dbg_req_i) w_state_nxt = DBG_ACCESS;
      end
      DBG_ACCESS: begin
        if (dbg_we_i) begin
          if (!we_i) w_state_nxt = DBG_DONE;
        end else begin
          w_capture   = 1'b1;
          w_state_nxt = DBG_DONE;
        end
      end
      DBG_DONE: begin
        w_ack       = 1'b1;
        w_state_nxt = DBG_IDLE;
      end
      default: w_state_nxt = DBG_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dbg_rdata <= '0;
    end else if (w_capture) begin
      r_dbg_rdata <= w_dbg_rv;
    end
  end

  assign dbg_ack_o   = w_ack;
  assign dbg_rdata_o = r_dbg_rdata;

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .NRD      (NRD),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_set      (iss_valid_i),
    .i_set_addr (iss_rd_i),
    .i_clr      (we_i),
    .i_clr_addr (waddr_i),
    .i_q_addr   (raddr_i),
    .o_q_busy   (rbusy_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_sb
// Description : Self-checking bench for regfile_sb. A default instance is
//               driven by directed and random traffic and compared against
//               an array/timeline model; a second instance (16 x 64, three
//               read ports, writable x0) is compared against its own array.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        iss;
  logic [4:0]  iss_rd;
  logic        dreq;
  logic        dwe;
  logic [4:0]  daddr;
  logic [31:0] dwdata;
  logic        dack;
  logic [31:0] drdata;

  logic         we2;
  logic [3:0]   waddr2;
  logic [63:0]  wdata2;
  logic [11:0]  raddr2;
  logic [191:0] rdata2;
  logic [2:0]   rbusy2;
  logic         dack2;
  logic [63:0]  drdata2;

  int n_total = 0;
  int n_bad   = 0;

  // Model of the default instance
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  int          m_phase;     // 0 idle, 1 access pending, 2 ack cycle
  logic [31:0] m_drd;
  logic [63:0] m2 [16];

  always #5 clk = ~clk;

  regfile_sb u_dut (
    .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .raddr_i(raddr), .rdata_o(rdata), .rbusy_o(rbusy),
    .iss_valid_i(iss), .iss_rd_i(iss_rd),
    .dbg_req_i(dreq), .dbg_we_i(dwe), .dbg_addr_i(daddr), .dbg_wdata_i(dwdata),
    .dbg_ack_o(dack), .dbg_rdata_o(drdata)
  );

  regfile_sb #(.XLEN(64), .NREGS(16), .NRD(3), .ZERO_REG(0)) u_dut2 (
    .clk(clk), .rst(rst), .we_i(we2), .waddr_i(waddr2), .wdata_i(wdata2),
    .raddr_i(raddr2), .rdata_o(rdata2), .rbusy_o(rbusy2),
    .iss_valid_i(1'b0), .iss_rd_i(4'd0),
    .dbg_req_i(1'b0), .dbg_we_i(1'b0), .dbg_addr_i(4'd0), .dbg_wdata_i(64'd0),
    .dbg_ack_o(dack2), .dbg_rdata_o(drdata2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0)               return 32'd0;
    if (we && (waddr == a))      return wdata;
    return m_regs[a];
  endfunction

  task automatic idle();
    rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
    iss = 1'b0; iss_rd = '0; dreq = 1'b0; dwe = 1'b0; daddr = '0; dwdata = '0;
  endtask

  task automatic check_outputs();
    #1;
    for (int k = 0; k < 2; k++) begin
      logic [4:0] a;
      a = raddr[k*5 +: 5];
      chk("rdata", {32'd0, rdata[k*32 +: 32]}, {32'd0, m_read(a)});
      chk("rbusy", {63'd0, rbusy[k]}, {63'd0, m_busy[a] && !(we && (waddr == a))});
    end
    chk("dbg_ack", {63'd0, dack}, {63'd0, m_phase == 2});
    chk("dbg_rdata", {32'd0, drdata}, {32'd0, m_drd});
  endtask

  // Apply the effects of the current cycle's inputs at the coming edge
  task automatic advance();
    int nph;
    nph = m_phase;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_busy[i] = 0; end
      nph = 0; m_drd = '0;
    end else begin
      case (m_phase)
        0: if (dreq) nph = 1;
        1: begin
          if (!dwe) begin
            m_drd = m_read(daddr); nph = 2;
          end else if (!we) begin
            if (daddr != 5'd0) m_regs[daddr] = dwdata;
            nph = 2;
          end
        end
        default: nph = 0;
      endcase
      if (we && (waddr != 5'd0)) m_regs[waddr] = wdata;
      if (we) m_busy[waddr] = 0;
      if (iss && (iss_rd != 5'd0)) m_busy[iss_rd] = 1;
    end
    m_phase = nph;
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    check_outputs();
    advance();
  endtask

  task automatic rand_cycle();
    rst    = ($urandom_range(0, 149) == 0);
    we     = 1'($urandom_range(0, 1));
    waddr  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
    wdata  = $urandom;
    raddr  = 10'($urandom);
    if ($urandom_range(0, 2) == 0) raddr[4:0] = waddr;
    if ($urandom_range(0, 1) == 0) raddr[9:5] = 5'($urandom_range(0, 7));
    iss    = ($urandom_range(0, 2) == 0);
    iss_rd = 5'($urandom_range(0, 7));
    if (m_phase == 0) begin
      dreq   = ($urandom_range(0, 3) == 0);
      dwe    = 1'($urandom_range(0, 1));
      daddr  = 5'($urandom_range(0, 7));
      dwdata = $urandom;
    end else begin
      dreq = 1'b1;
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_busy[i] = 0; end
    m_phase = 0; m_drd = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset clears stored data
    idle(); we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; step();
    idle(); rst = 1'b1; step();
    idle(); raddr = {5'd0, 5'd5}; check_outputs();
    chk("rst_rd", {32'd0, rdata[31:0]}, 64'd0);
    chk("rst_busy", {63'd0, rbusy[0]}, 64'd0);
    advance();

    // Bypass and x0
    idle(); we = 1'b1; waddr = 5'd3; wdata = 32'h12345678; raddr = {5'd0, 5'd3};
    check_outputs(); chk("bypass", {32'd0, rdata[31:0]}, 64'h12345678); advance();
    idle(); we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr = {5'd0, 5'd0};
    check_outputs(); chk("x0_byp", {32'd0, rdata[31:0]}, 64'd0); advance();
    idle(); check_outputs(); chk("x0_rd", {32'd0, rdata[31:0]}, 64'd0); advance();

    // Scoreboard
    idle(); iss = 1'b1; iss_rd = 5'd7; step();
    idle(); raddr = {5'd7, 5'd0};
    check_outputs(); chk("busy_set", {63'd0, rbusy[1]}, 64'd1); advance();
    idle(); we = 1'b1; waddr = 5'd7; wdata = 32'h70; raddr = {5'd7, 5'd0};
    check_outputs(); chk("busy_byp", {63'd0, rbusy[1]}, 64'd0); advance();
    idle(); iss = 1'b1; iss_rd = 5'd7; we = 1'b1; waddr = 5'd7; wdata = 32'h71; step();
    idle(); raddr = {5'd7, 5'd0};
    check_outputs(); chk("busy_setwins", {63'd0, rbusy[1]}, 64'd1); advance();
    idle(); we = 1'b1; waddr = 5'd7; wdata = 32'h72; step();

    // Debug read, ack two cycles after request
    idle(); we = 1'b1; waddr = 5'd4; wdata = 32'hA5A5A5A5; step();
    idle(); dreq = 1'b1; dwe = 1'b0; daddr = 5'd4; step();
    step();
    check_outputs();
    chk("dbgrd_ack", {63'd0, dack}, 64'd1);
    chk("dbgrd_data", {32'd0, drdata}, 64'hA5A5A5A5);
    advance();

    // Debug write deferred by three cycles of core writeback
    idle(); dreq = 1'b1; dwe = 1'b1; daddr = 5'd9; dwdata = 32'h1; raddr = {5'd0, 5'd9}; step();
    we = 1'b1; waddr = 5'd9; wdata = 32'h77; step();
    waddr = 5'd2; wdata = 32'h22; step();
    check_outputs(); chk("coll_noack", {63'd0, dack}, 64'd0); advance();
    we = 1'b0;
    check_outputs(); chk("coll_wait", {32'd0, rdata[31:0]}, 64'h77); advance();
    check_outputs();
    chk("coll_ack", {63'd0, dack}, 64'd1);
    chk("coll_data", {32'd0, rdata[31:0]}, 64'h1);
    advance();

    // Reset mid-transaction: no write, no ack
    idle(); dreq = 1'b1; dwe = 1'b1; daddr = 5'd10; dwdata = 32'h5; step();
    rst = 1'b1; step();
    idle(); raddr = {5'd0, 5'd10}; step();
    check_outputs();
    chk("rstmid_ack", {63'd0, dack}, 64'd0);
    chk("rstmid_data", {32'd0, rdata[31:0]}, 64'd0);
    advance();

    // Random traffic
    for (int c = 0; c < 2500; c++) begin
      rand_cycle();
      step();
    end

    // Second instance: 16 x 64, three read ports, x0 writable
    idle(); rst = 1'b1;
    we2 = 1'b0; waddr2 = '0; wdata2 = '0; raddr2 = '0;
    for (int i = 0; i < 16; i++) m2[i] = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    we2 = 1'b1; waddr2 = 4'd0; wdata2 = 64'hCAFEF00D_01234567; m2[0] = wdata2;
    @(posedge clk); #1;
    we2 = 1'b0; raddr2 = 12'h000; #1;
    chk("p2_x0", rdata2[63:0], 64'hCAFEF00D_01234567);
    for (int c = 0; c < 400; c++) begin
      we2    = 1'($urandom_range(0, 1));
      waddr2 = 4'($urandom);
      wdata2 = {$urandom, $urandom};
      raddr2 = 12'($urandom);
      if ($urandom_range(0, 2) == 0) raddr2[7:4] = waddr2;
      #1;
      for (int k = 0; k < 3; k++) begin
        logic [3:0]  a;
        logic [63:0] e;
        a = raddr2[k*4 +: 4];
        e = (we2 && (waddr2 == a)) ? wdata2 : m2[a];
        chk("p2_rdata", rdata2[k*64 +: 64], e);
      end
      chk("p2_rbusy", {61'd0, rbusy2}, 64'd0);
      if (we2) m2[waddr2] = wdata2;
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
